// File: rtl/custom_write_master_if.sv
// Bundles the control, user-buffer and Avalon-MM write signals of custom_write_master.
// The master modport is the block itself; slave is whatever drives and observes it.
interface custom_write_master_if #(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRESSWIDTH = 28
);
  logic                      control_fixed_location;
  logic [ADDRESSWIDTH-1:0]   control_write_base;
  logic [ADDRESSWIDTH-1:0]   control_write_length;
  logic                      control_go;
  logic                      control_done;
  logic                      user_write_buffer;
  logic [DATAWIDTH-1:0]      user_buffer_data;
  logic                      user_buffer_full;
  logic [ADDRESSWIDTH-1:0]   master_address;
  logic                      master_write;
  logic [DATAWIDTH/8-1:0]    master_byteenable;
  logic [DATAWIDTH-1:0]      master_writedata;
  logic                      master_waitrequest;

  modport master (
    input  control_fixed_location, control_write_base, control_write_length, control_go,
    input  user_write_buffer, user_buffer_data, master_waitrequest,
    output control_done, user_buffer_full,
    output master_address, master_write, master_byteenable, master_writedata
  );

  modport slave (
    output control_fixed_location, control_write_base, control_write_length, control_go,
    output user_write_buffer, user_buffer_data, master_waitrequest,
    input  control_done, user_buffer_full,
    input  master_address, master_write, master_byteenable, master_writedata
  );
endinterface

// File: rtl/custom_write_master.sv
// Avalon-MM write master: drains a user-filled FIFO to incrementing or fixed addresses
// for a byte length given at go. All outputs decode from registers.
module custom_write_master #(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRESSWIDTH = 28,
  parameter int FIFODEPTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  custom_write_master_if.master bus
);
  localparam int BYTES = DATAWIDTH / 8;
  localparam int PW    = $clog2(FIFODEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [ADDRESSWIDTH-1:0] remain_q, remain_d;
  logic                    fixed_q, fixed_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [DATAWIDTH-1:0]    mem [FIFODEPTH];

  logic full, write, push, pop, go_ok, last;

  assign full  = (count_q == CW'(FIFODEPTH));
  assign write = (state_q == ACTIVE) && (count_q != '0);
  // A push while full is dropped even if this cycle also pops.
  assign push  = bus.user_write_buffer && !full;
  assign pop   = write && !bus.master_waitrequest;
  assign go_ok = (state_q == IDLE) && bus.control_go &&
                 (bus.control_write_length[ADDRESSWIDTH-1:2] != '0);
  assign last  = (remain_q <= ADDRESSWIDTH'(BYTES));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    fixed_d  = fixed_q;
    unique case (state_q)
      IDLE: begin
        if (go_ok) begin
          state_d  = ACTIVE;
          addr_d   = bus.control_write_base;
          remain_d = {bus.control_write_length[ADDRESSWIDTH-1:2], 2'b00};
          fixed_d  = bus.control_fixed_location;
        end
      end
      ACTIVE: begin
        if (pop) begin
          remain_d = last ? '0 : remain_q - ADDRESSWIDTH'(BYTES);
          if (!fixed_q) addr_d = addr_q + ADDRESSWIDTH'(BYTES);
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      fixed_q  <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      fixed_q  <= fixed_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: only words below count_q are ever presented.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.user_buffer_data;
  end

  assign bus.control_done      = (state_q == IDLE);
  assign bus.user_buffer_full  = full;
  assign bus.master_address    = addr_q;
  assign bus.master_write      = write;
  assign bus.master_byteenable = '1;
  assign bus.master_writedata  = mem[rd_ptr_q];
endmodule
